// File: rtl/cook_timer_ctrl.sv
// Microwave cook timer: keypad MM:SS entry, per-second countdown,
// door interlock and pause/resume control of the magnetron.
module cook_timer_ctrl #(
   parameter int TICKS_PER_SEC = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       key_valid,
   input  logic [3:0] key_digit,
   input  logic       start,
   input  logic       stop_clear,
   input  logic       door_closed,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       magnetron_on,
   output logic       done,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'b000,
      S_ENTRY = 3'b001,
      S_COOK  = 3'b010,
      S_PAUSE = 3'b011,
      S_DONE  = 3'b100
   } state_t;

   localparam logic [6:0] SUB_LAST = 7'(TICKS_PER_SEC - 1);

   state_t     state_q, state_d;
   logic [3:0] mt_q, mt_d, mo_q, mo_d, st_q, st_d, so_q, so_d;
   logic [6:0] sub_q, sub_d;
   logic       done_q, done_d;

   logic       key_ok, door_open, time_zero;
   logic       b1, b2, b3;
   logic [3:0] mt_n, mo_n, st_n, so_n;

   // One-second borrow chain; seconds tens wraps to 5, others to 9
   always_comb begin
      b1   = (so_q == 4'd0);
      b2   = b1 && (st_q == 4'd0);
      b3   = b2 && (mo_q == 4'd0);
      so_n = b1 ? 4'd9 : so_q - 4'd1;
      st_n = b1 ? ((st_q == 4'd0) ? 4'd5 : st_q - 4'd1) : st_q;
      mo_n = b2 ? ((mo_q == 4'd0) ? 4'd9 : mo_q - 4'd1) : mo_q;
      mt_n = b3 ? ((mt_q == 4'd0) ? 4'd9 : mt_q - 4'd1) : mt_q;
   end

   always_comb begin
      state_d   = state_q;
      mt_d      = mt_q;
      mo_d      = mo_q;
      st_d      = st_q;
      so_d      = so_q;
      sub_d     = sub_q;
      done_d    = 1'b0;
      key_ok    = key_valid && (key_digit <= 4'd9);
      door_open = !door_closed;
      time_zero = ({mt_q, mo_q, st_q, so_q} == 16'h0000);
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (stop_clear) begin
               state_d = S_IDLE;
               {mt_d, mo_d, st_d, so_d} = 16'h0000;
            end else if (door_open) begin
               state_d = state_q;
            end else if (start) begin
               {mt_d, mo_d, st_d, so_d} = 16'h0030;
               sub_d   = 7'd0;
               state_d = S_COOK;
            end else if (key_ok) begin
               {mt_d, mo_d, st_d, so_d} = {12'h000, key_digit};
               state_d = S_ENTRY;
            end
         end
         S_ENTRY: begin
            if (stop_clear) begin
               state_d = S_IDLE;
               {mt_d, mo_d, st_d, so_d} = 16'h0000;
            end else if (door_open) begin
               state_d = S_ENTRY;
            end else if (start) begin
               if (!time_zero) begin
                  sub_d   = 7'd0;
                  state_d = S_COOK;
               end
            end else if (key_ok) begin
               {mt_d, mo_d, st_d, so_d} = {mo_q, st_q, so_q, key_digit};
            end
         end
         S_COOK: begin
            if (stop_clear || door_open) begin
               state_d = S_PAUSE;
            end else if (tick) begin
               if (sub_q == SUB_LAST) begin
                  sub_d = 7'd0;
                  {mt_d, mo_d, st_d, so_d} = {mt_n, mo_n, st_n, so_n};
                  if ({mt_n, mo_n, st_n, so_n} == 16'h0000) begin
                     state_d = S_DONE;
                     done_d  = 1'b1;
                  end
               end else begin
                  sub_d = sub_q + 7'd1;
               end
            end
         end
         S_PAUSE: begin
            if (stop_clear) begin
               state_d = S_IDLE;
               {mt_d, mo_d, st_d, so_d} = 16'h0000;
            end else if (door_open) begin
               state_d = S_PAUSE;
            end else if (start) begin
               sub_d   = 7'd0;
               state_d = S_COOK;
            end
         end
         default: begin
            state_d = S_IDLE;
            {mt_d, mo_d, st_d, so_d} = 16'h0000;
            sub_d   = 7'd0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         mt_q    <= 4'd0;
         mo_q    <= 4'd0;
         st_q    <= 4'd0;
         so_q    <= 4'd0;
         sub_q   <= 7'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mt_q    <= mt_d;
         mo_q    <= mo_d;
         st_q    <= st_d;
         so_q    <= so_d;
         sub_q   <= sub_d;
         done_q  <= done_d;
      end
   end

   assign min_tens     = mt_q;
   assign min_ones     = mo_q;
   assign sec_tens     = st_q;
   assign sec_ones     = so_q;
   assign magnetron_on = (state_q == S_COOK);
   assign done         = done_q;
   assign state        = state_q;

endmodule

// File: doc/cook_timer_ctrl.md
COOK_TIMER_CTRL -- requirements
Module: cook_timer_ctrl

Interface
REQ-001 Parameter TICKS_PER_SEC, default 10: number of tick pulses per counted second; legal range 2-127.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 tick  input  1  one-cycle pulse from the 1/10 s frequency divider.
REQ-005 key_valid  input  1  one-cycle strobe; key_digit is valid in the same cycle.
REQ-006 key_digit  input  4  BCD keypad digit; values 10-15 are illegal.
REQ-007 start  input  1  one-cycle start/resume strobe.
REQ-008 stop_clear  input  1  one-cycle stop/clear strobe.
REQ-009 door_closed  input  1  door-switch level; 1 = closed.
REQ-010 min_tens, min_ones, sec_tens, sec_ones  output  4 each  BCD display of the remaining time (MM:SS).
REQ-011 magnetron_on  output  1  heater enable.
REQ-012 done  output  1  one-cycle pulse on cook completion.
REQ-013 state  output  3  encoding: IDLE=000, ENTRY=001, COOK=010, PAUSE=011, DONE=100.

Function
REQ-014 State, digits and the sub-second counter (sub_cnt, 7 bit) are registers; magnetron_on is high exactly while state==COOK.
REQ-015 Input priority per cycle: stop_clear, then door open, then start, then key_valid; lower-priority strobes in the same cycle are ignored.
REQ-016 key_valid with key_digit > 9 is ignored in all states.
REQ-017 Digit entry: the displayed digits shift left one position and the new digit enters sec_ones; min_tens is discarded.
REQ-018 IDLE: key_valid clears the digits, shifts in the digit and goes to ENTRY; start with door_closed loads 00:30, clears sub_cnt and goes to COOK; start with the door open is ignored.
REQ-019 ENTRY: key_valid shifts a digit; start with door_closed and a nonzero time clears sub_cnt and goes to COOK; start with a zero time or the door open is ignored; stop_clear clears the digits and goes to IDLE.
REQ-020 COOK: tick increments sub_cnt; a tick with sub_cnt==TICKS_PER_SEC-1 sets sub_cnt to 0 and decrements the time by one second.
REQ-021 Decrement rule: sec_ones-1; at sec_ones==0, sec_ones=9 with a borrow to sec_tens; at sec_tens==0 with a borrow, sec_tens=5 with a borrow to minutes (same rule for min_ones/min_tens). sec_tens values above 5 entered from the keypad count down unmodified.
REQ-022 COOK: a decrement that yields 00:00 goes to DONE on the same edge; done is high for exactly the following cycle.
REQ-023 COOK: door_closed==0 or stop_clear goes to PAUSE; time and sub_cnt are frozen and the tick in that cycle is not counted.
REQ-024 PAUSE: start with door_closed clears sub_cnt and goes to COOK; stop_clear clears the digits and goes to IDLE; tick and key_valid are ignored.
REQ-025 DONE: time holds 00:00; key_valid behaves as in IDLE; start behaves as in IDLE; stop_clear goes to IDLE.
REQ-026 A door opening in any state other than COOK causes no state change.
REQ-027 The digit registers never hold values above 9.

Reset
REQ-028 Reset asserted forces, without waiting for a clock edge: state=IDLE, all digits=0, sub_cnt=0, magnetron_on=0, done=0.
REQ-029 Reset asserted mid-cook takes effect immediately; operation resumes in IDLE on the first clock edge after deassertion.

Verification (TICKS_PER_SEC=10)
REQ-030 Keys 1,3,0 -> display 01:30, state ENTRY; start with door closed -> COOK, magnetron_on=1; 10 ticks -> 01:29.
REQ-031 Load 1,0,0 (01:00) and cook; 10 ticks -> 00:59; another 590 ticks -> 00:00, DONE, done high for 1 cycle, magnetron_on=0.
REQ-032 Cook 00:05; after 23 ticks open the door -> PAUSE, display 00:03; 50 more ticks -> still 00:03; close the door and start -> COOK; 10 ticks -> 00:02.
REQ-033 IDLE with door open: start -> stays IDLE; close the door and start -> 00:30 COOK; stop_clear -> PAUSE; stop_clear -> IDLE, 00:00.
REQ-034 Keys 1,2,3,4,5 -> 23:45; key_digit 12 -> no change; start and stop_clear in the same cycle in ENTRY -> IDLE, 00:00.
REQ-035 Assert rst asynchronously mid-cook at 00:40 -> state=000, digits 0, magnetron_on=0 before the next clock edge.
